// File: rtl/mem_stage_access_pkg.sv
// Shared widths, timeout default and FSM encoding for the MEM stage.
package mem_stage_access_pkg;

    localparam int ADDR_LEN        = 32;
    localparam int DATA_LEN        = 32;
    localparam int REG_ADDR_LEN    = 5;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_stage_access_if.sv
// Request/acknowledge data-memory bus; the MEM stage is master, the memory is slave.
interface mem_stage_access_if;
    import mem_stage_access_pkg::*;

    logic                dmem_req;
    logic                dmem_we;
    logic [ADDR_LEN-1:0] dmem_addr;
    logic [DATA_LEN-1:0] dmem_wdata;
    logic                dmem_ack;
    logic [DATA_LEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/pipeline_reg_mem_wb.sv
// MEM/WB pipeline register: full load when the stage advances, control-only bubble on stall.
module pipeline_reg_mem_wb
    import mem_stage_access_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic                    i_bubble,
    input  logic [ADDR_LEN-1:0]     i_pc,
    input  logic [DATA_LEN-1:0]     i_alu_result,
    input  logic [DATA_LEN-1:0]     i_mem_rdata,
    input  logic [REG_ADDR_LEN-1:0] i_write_reg_addr,
    input  logic                    i_mem_to_reg,
    input  logic                    i_reg_write,
    output logic [ADDR_LEN-1:0]     o_pc,
    output logic [DATA_LEN-1:0]     o_alu_result,
    output logic [DATA_LEN-1:0]     o_mem_rdata,
    output logic [REG_ADDR_LEN-1:0] o_write_reg_addr,
    output logic                    o_mem_to_reg,
    output logic                    o_reg_write
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc             <= '0;
            o_alu_result     <= '0;
            o_mem_rdata      <= '0;
            o_write_reg_addr <= '0;
            o_mem_to_reg     <= 1'b0;
            o_reg_write      <= 1'b0;
        end else if (i_bubble) begin
            // Only the control fields are cleared; data fields hold their last value.
            o_write_reg_addr <= '0;
            o_mem_to_reg     <= 1'b0;
            o_reg_write      <= 1'b0;
        end else if (i_load) begin
            o_pc             <= i_pc;
            o_alu_result     <= i_alu_result;
            o_mem_rdata      <= i_mem_rdata;
            o_write_reg_addr <= i_write_reg_addr;
            o_mem_to_reg     <= i_mem_to_reg;
            o_reg_write      <= i_reg_write;
        end
    end

endmodule

// File: rtl/mem_stage_access.sv
// MEM-stage controller: issues variable-latency data-memory accesses, stalls the
// pipeline while one is outstanding, and owns the MEM/WB register.
module mem_stage_access
    import mem_stage_access_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_LEN-1:0]     pc_mem,
    input  logic [DATA_LEN-1:0]     alu_result_mem,
    input  logic [DATA_LEN-1:0]     reg2_data_mem,
    input  logic [REG_ADDR_LEN-1:0] write_reg_addr_mem,
    input  logic                    mem_to_reg_flag_mem,
    input  logic                    reg_write_flag_mem,
    input  logic                    mem_read_flag_mem,
    input  logic                    mem_write_flag_mem,
    mem_stage_access_if.master      dmem,
    output logic                    mem_stall,
    output logic                    mem_err,
    output logic [ADDR_LEN-1:0]     pc_wb,
    output logic [DATA_LEN-1:0]     alu_result_wb,
    output logic [DATA_LEN-1:0]     mem_rdata_wb,
    output logic [REG_ADDR_LEN-1:0] write_reg_addr_wb,
    output logic                    mem_to_reg_flag_wb,
    output logic                    reg_write_flag_wb
);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_req;
    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [DATA_LEN-1:0] r_wdata;
    logic [DATA_LEN-1:0] r_rdata;
    logic                r_err;
    logic                r_abort;

    logic                w_access;
    logic                w_misaligned;
    logic                w_issue;
    logic                w_timeout;
    logic [DATA_LEN-1:0] w_wb_rdata;
    logic                w_wb_reg_write;

    assign w_access     = mem_read_flag_mem | mem_write_flag_mem;
    assign w_misaligned = w_access & (alu_result_mem[1:0] != 2'b00);
    assign w_issue      = (r_state == ST_IDLE) & w_access & ~w_misaligned;
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        mem_stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    mem_stall    = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_stall = 1'b1;
                if (dmem.dmem_ack || w_timeout) w_state_next = ST_DONE;
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_req   <= 1'b1;
                        r_we    <= mem_write_flag_mem;
                        r_addr  <= alu_result_mem;
                        r_wdata <= reg2_data_mem;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                    end else if (w_misaligned) begin
                        r_err <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (dmem.dmem_ack) begin
                        r_rdata <= dmem.dmem_rdata;
                        r_req   <= 1'b0;
                    end else if (w_timeout) begin
                        r_req   <= 1'b0;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign mem_err         = r_err;

    // Read-and-write counts as a store, so only a pure load forwards read data.
    assign w_wb_rdata     = (mem_read_flag_mem & ~mem_write_flag_mem) ? r_rdata : '0;
    assign w_wb_reg_write = reg_write_flag_mem & ~w_misaligned
                          & ~((r_state == ST_DONE) & r_abort);

    pipeline_reg_mem_wb u_mem_wb (
        .clk              (clk),
        .rst              (rst),
        .i_load           (~mem_stall),
        .i_bubble         (mem_stall),
        .i_pc             (pc_mem),
        .i_alu_result     (alu_result_mem),
        .i_mem_rdata      (w_wb_rdata),
        .i_write_reg_addr (write_reg_addr_mem),
        .i_mem_to_reg     (mem_to_reg_flag_mem),
        .i_reg_write      (w_wb_reg_write),
        .o_pc             (pc_wb),
        .o_alu_result     (alu_result_wb),
        .o_mem_rdata      (mem_rdata_wb),
        .o_write_reg_addr (write_reg_addr_wb),
        .o_mem_to_reg     (mem_to_reg_flag_wb),
        .o_reg_write      (reg_write_flag_wb)
    );

endmodule

// File: tb/tb_mem_stage_access.sv
// Directed bench for mem_stage_access: a scoreboard of expected MEM/WB contents
// is filled when an instruction is driven and drained when the stage advances.
module tb_mem_stage_access;
    import mem_stage_access_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        m2r;
        logic        rw;
        logic        chk_rdata;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_mem = '0;
    logic [31:0] alu_result_mem = '0;
    logic [31:0] reg2_data_mem = '0;
    logic [4:0]  write_reg_addr_mem = '0;
    logic        mem_to_reg_flag_mem = 1'b0;
    logic        reg_write_flag_mem = 1'b0;
    logic        mem_read_flag_mem = 1'b0;
    logic        mem_write_flag_mem = 1'b0;
    logic        mem_stall;
    logic        mem_err;
    logic [31:0] pc_wb;
    logic [31:0] alu_result_wb;
    logic [31:0] mem_rdata_wb;
    logic [4:0]  write_reg_addr_wb;
    logic        mem_to_reg_flag_wb;
    logic        reg_write_flag_wb;

    int   total = 0;
    int   bad = 0;
    logic exp_err = 1'b0;
    wb_t  sb[$];

    mem_stage_access_if bus();

    always #5 clk = ~clk;

    mem_stage_access #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .pc_mem              (pc_mem),
        .alu_result_mem      (alu_result_mem),
        .reg2_data_mem       (reg2_data_mem),
        .write_reg_addr_mem  (write_reg_addr_mem),
        .mem_to_reg_flag_mem (mem_to_reg_flag_mem),
        .reg_write_flag_mem  (reg_write_flag_mem),
        .mem_read_flag_mem   (mem_read_flag_mem),
        .mem_write_flag_mem  (mem_write_flag_mem),
        .dmem                (bus),
        .mem_stall           (mem_stall),
        .mem_err             (mem_err),
        .pc_wb               (pc_wb),
        .alu_result_wb       (alu_result_wb),
        .mem_rdata_wb        (mem_rdata_wb),
        .write_reg_addr_wb   (write_reg_addr_wb),
        .mem_to_reg_flag_wb  (mem_to_reg_flag_wb),
        .reg_write_flag_wb   (reg_write_flag_wb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, alu, wdata, input logic [4:0] rd,
                         input logic m2r, rw, rdf, wrf);
        pc_mem              = pc;
        alu_result_mem      = alu;
        reg2_data_mem       = wdata;
        write_reg_addr_mem  = rd;
        mem_to_reg_flag_mem = m2r;
        reg_write_flag_mem  = rw;
        mem_read_flag_mem   = rdf;
        mem_write_flag_mem  = wrf;
    endtask

    // ack_on: BUSY cycle (1-based) in which the memory acknowledges; 0 = never.
    task automatic run_instr(input logic [31:0] pc, alu, wdata, input logic [4:0] rd,
                             input logic m2r, rw, rdf, wrf,
                             input int ack_on, input logic [31:0] rdata);
        logic access, mis, timed_out, st, rq, prev, done;
        int   exp_req, reqs, stalls, busy, rises;
        wb_t  e;
        access    = rdf | wrf;
        mis       = access && (alu[1:0] != 2'b00);
        exp_req   = (access && !mis) ? ((ack_on > 0) ? ack_on : 16) : 0;
        timed_out = access && !mis && (ack_on <= 0);
        e.pc        = pc;
        e.alu       = alu;
        e.rd        = rd;
        e.m2r       = m2r;
        e.rw        = rw & !mis & !timed_out;
        e.rdata     = (rdf && !wrf && !timed_out) ? rdata : 32'h0;
        e.chk_rdata = !mis;
        sb.push_back(e);
        if (mis || timed_out) exp_err = 1'b1;
        drive(pc, alu, wdata, rd, m2r, rw, rdf, wrf);

        reqs = 0; stalls = 0; busy = 0; rises = 0; prev = 1'b0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            st = mem_stall;
            rq = bus.dmem_req;
            if (st) stalls++;
            if (rq) begin
                reqs++;
                busy++;
                if (!prev) rises++;
                if (busy == 1) begin
                    check("bus_we", bus.dmem_we, wrf);
                    check("bus_addr", bus.dmem_addr, alu);
                    if (wrf) check("bus_wdata", bus.dmem_wdata, wdata);
                end
                bus.dmem_ack   = (busy == ack_on);
                bus.dmem_rdata = (busy == ack_on) ? rdata : ~rdata;
            end else begin
                bus.dmem_ack = 1'b0;
            end
            prev = rq;
            @(posedge clk);
            #1;
            bus.dmem_ack = 1'b0;
            if (st) begin
                check("bubble_rw", reg_write_flag_wb, 1'b0);
                check("bubble_rd", write_reg_addr_wb, 5'd0);
            end else begin
                done = 1'b1;
                e = sb.pop_front();
                check("wb_pc", pc_wb, e.pc);
                check("wb_alu", alu_result_wb, e.alu);
                if (e.chk_rdata) check("wb_rdata", mem_rdata_wb, e.rdata);
                check("wb_rd", write_reg_addr_wb, e.rd);
                check("wb_m2r", mem_to_reg_flag_wb, e.m2r);
                check("wb_rw", reg_write_flag_wb, e.rw);
            end
        end
        if (!done) sb.delete();
        check("done_in_budget", done, 1'b1);
        check("req_cycles", reqs, exp_req);
        check("stall_cycles", stalls, (exp_req > 0) ? exp_req + 1 : 0);
        check("req_issues", rises, (exp_req > 0) ? 1 : 0);
        check("mem_err", mem_err, exp_err);
    endtask

    initial begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        #1;
        check("rst_req", bus.dmem_req, 1'b0);
        check("rst_we", bus.dmem_we, 1'b0);
        check("rst_addr", bus.dmem_addr, 32'h0);
        check("rst_wdata", bus.dmem_wdata, 32'h0);
        check("rst_err", mem_err, 1'b0);
        check("rst_stall", mem_stall, 1'b0);
        check("rst_pc_wb", pc_wb, 32'h0);
        check("rst_rw_wb", reg_write_flag_wb, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Non-memory op, load with 2-cycle latency, store acked at once.
        run_instr(32'h1000, 32'h0000_0055, 32'h0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        run_instr(32'h1004, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 2, 32'hDEAD_BEEF);
        run_instr(32'h1008, 32'h0000_0200, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
        // Misaligned load, then a load that never gets an ack.
        run_instr(32'h100C, 32'h0000_0102, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h0);
        run_instr(32'h1010, 32'h0000_0104, 32'h0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h5555_AAAA);
        run_instr(32'h1014, 32'h0000_0077, 32'h0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);

        // Reset in the middle of a BUSY access.
        drive(32'h1018, 32'h0000_0300, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", bus.dmem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", bus.dmem_req, 1'b0);
        check("arst_err", mem_err, 1'b0);
        check("arst_pc_wb", pc_wb, 32'h0);
        check("arst_alu_wb", alu_result_wb, 32'h0);
        check("arst_rdata_wb", mem_rdata_wb, 32'h0);
        check("arst_rd_wb", write_reg_addr_wb, 5'd0);
        check("arst_m2r_wb", mem_to_reg_flag_wb, 1'b0);
        check("arst_rw_wb", reg_write_flag_wb, 1'b0);
        exp_err = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(32'h101C, 32'h0000_0400, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1, 1'b0, 3, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
